uart_block_assembler: RTL and testbench
=======================================

Name: uart_block_assembler

Overview:
Sits directly downstream of the UART receiver. It consumes the receiver's byte output (uart_d_out/uart_valid) and packs BLOCK_BYTES consecutive bytes into one wide block for the AES-128 core: key or plaintext, 128 bits at defaults. It presents the block on a valid/ready handshake. An inter-byte timeout discards partial blocks, and a sticky flag records bytes lost while a finished block waits.

Parameters:
BLOCK_BYTES, 16, bytes per output block; output width = 8*BLOCK_BYTES.
baud_rate, 24'd4000000, UART bit rate; must match the upstream receiver.
clock_freq, 28'd50000000, uart_clock frequency in Hz.
TIMEOUT_BYTES, 4, idle gap in byte-times that aborts a partial block.
Derived: BYTE_CYCLES = 10*clock_freq/baud_rate (125 at defaults); TIMEOUT_CYCLES = TIMEOUT_BYTES*BYTE_CYCLES (500 at defaults).

Ports:
uart_clock  in  1  system clock; one clock domain only.
uart_reset  in  1  asynchronous, active-low reset.
rx_data  in  8  received byte; connect to the receiver's uart_d_out.
rx_valid  in  1  connect to the receiver's uart_valid. This is a level that may stay high for many cycles.
blk_data  out  8*BLOCK_BYTES  assembled block. The first byte received is in bits [8*BLOCK_BYTES-1 -: 8].
blk_valid  out  1  block available.
blk_ready  in  1  consumer accepts the block.
busy  out  1  high in COLLECT or HOLD.
overflow  out  1  sticky; set when a byte is dropped.
timeout_err  out  1  one-cycle pulse when a partial block is discarded.

Behaviour:
- Clock and reset: one clock, uart_clock. Reset uart_reset is asynchronous and active-low.
- Reset values: all outputs 0, blk_data 0, rx_valid_q 0, byte count 0, timeout counter 0, state IDLE. Reset mid-block discards the partial block with no error flag.
- Byte accept:
  - accept = rx_valid & ~rx_valid_q, where rx_valid_q is rx_valid registered one cycle.
  - Exactly one accept per rising edge of rx_valid. A long high level is never re-counted.
- Byte placement:
  - The k-th accepted byte (k = 0..BLOCK_BYTES-1) is written to blk_data[8*(BLOCK_BYTES-k)-1 -: 8] at the clock edge ending the accept cycle.
  - The byte count is 5 bits at default and wraps only through state transitions.
- IDLE:
  - accept stores byte 0, count=1, goes to COLLECT.
  - blk_valid = 0, timeout counter held at 0.
- COLLECT:
  - accept stores the byte, count+1, clears the timeout counter.
  - On the accept that stores byte BLOCK_BYTES-1: go to HOLD, blk_valid=1 on the next cycle (latency 1 cycle after the final accept cycle).
  - No accept: timeout counter +1. If it equals TIMEOUT_CYCLES-1: go to IDLE, count=0, timeout_err=1 for one cycle; blk_data contents are don't-care.
  - If accept and timeout coincide, accept wins.
- HOLD:
  - blk_valid=1 and blk_data stable until the handshake.
  - The handshake is blk_valid & blk_ready. blk_valid drops the next cycle and the state goes to IDLE.
  - accept in the same cycle as the handshake: the byte becomes byte 0 of the next block, count=1, next state COLLECT. No overflow.
  - accept without the handshake: the byte is dropped and overflow is set. overflow clears only on reset.
  - No timeout is counted in HOLD.
- blk_ready while not in HOLD is ignored.
- busy = (state != IDLE), registered.
- Illegal state encoding returns to IDLE.

Decomposition:
- Shared package uart_pkg:
  - state enum typedef {IDLE, COLLECT, HOLD} in logic [1:0].
  - Default baud_rate/clock_freq constants, shared with uart_rx/uart_tx.
  - Function computing BYTE_CYCLES.
- One sub-module, uart_idle_timer: a counter with clear/enable inputs and a terminal-count pulse (TIMEOUT_CYCLES parameter). It is reusable by the transmit side for its inter-frame gap.
- Edge detect and the packing register stay in the top module.

Test Plan:
- Full block: 16 accepts with rx_valid held high 3 cycles each, bytes 0x00..0x0F, blk_ready=1 → a single blk_valid pulse with blk_data=128'h000102030405060708090A0B0C0D0E0F, overflow=0.
- Level hold: rx_valid held high 40 cycles, then 15 more single-cycle pulses → exactly one block completes; the 40-cycle level is counted once.
- Timeout: 5 bytes, then a 500-cycle silence → timeout_err pulses once at cycle 499 of the gap, busy=0. The next 16 bytes 0xA0..0xAF give blk_data=128'hA0A1...AF.
- Backpressure: block complete, blk_ready=0 for 300 cycles, one byte arrives → overflow=1, blk_data unchanged. blk_ready=1 → blk_valid falls the next cycle, overflow stays 1.
- Coincident accept and handshake: the 17th byte 0x55 arrives in the handshake cycle → next state COLLECT, count=1, blk_data[127:120]=0x55, overflow=0.
- Async reset after byte 7: assert uart_reset low mid-cycle → all outputs 0 immediately. After release, 16 new bytes form a correct block.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: block-assembler states, default line settings
// and the byte-time helper used by uart_rx/uart_tx/uart_block_assembler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [23:0] DEFAULT_BAUD_RATE  = 24'd4000000;
  localparam logic [27:0] DEFAULT_CLOCK_FREQ = 28'd50000000;

  // One frame is 10 bit-times: start, 8 data, stop.
  function automatic int byte_cycles(
    input logic [27:0] clk_hz,
    input logic [23:0] baud
  );
    longint num;
    num = 64'd10 * 64'(clk_hz);
    return int'(num / 64'(baud));
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Idle-gap counter: clear wins, counts while enabled, pulses expired on
// the cycle it sits at TIMEOUT_CYCLES-1 and then restarts from zero.
module uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic uart_clock,
  input  logic uart_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] cnt;

  assign expired = enable & ~clear &
                   (cnt == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      cnt <= '0;
    end else if (clear || expired) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_block_assembler.sv
// Packs consecutive UART bytes (first byte in the MSBs) into one block
// and offers it on valid/ready; drops partial blocks after an idle gap.
module uart_block_assembler
  import uart_pkg::*;
#(
  parameter int          BLOCK_BYTES   = 16,
  parameter logic [23:0] baud_rate     = DEFAULT_BAUD_RATE,
  parameter logic [27:0] clock_freq    = DEFAULT_CLOCK_FREQ,
  parameter int          TIMEOUT_BYTES = 4
) (
  input  logic                     uart_clock,
  input  logic                     uart_reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [8*BLOCK_BYTES-1:0] blk_data,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic                     busy,
  output logic                     overflow,
  output logic                     timeout_err
);

  localparam int BYTE_CYCLES =
    byte_cycles(clock_freq, baud_rate);
  localparam int TIMEOUT_CYCLES =
    TIMEOUT_BYTES * BYTE_CYCLES;
  localparam int CNT_W = $clog2(BLOCK_BYTES + 1);
  localparam state_t FIRST_NEXT =
    (BLOCK_BYTES == 1) ? HOLD : COLLECT;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               rx_valid_q;
  logic               accept;
  logic               wr_en;
  logic [CNT_W-1:0]   wr_idx;
  logic [8*BLOCK_BYTES-1:0] data_d;
  logic               ovf_d, terr_d;
  logic               tmr_clr, tmr_en, tmr_exp;

  // rx_valid is a level; only its rising edge carries a new byte.
  assign accept = rx_valid & ~rx_valid_q;

  assign blk_valid = (state == HOLD);
  assign busy      = (state == COLLECT) | (state == HOLD);

  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .uart_clock(uart_clock),
    .uart_reset(uart_reset),
    .clear     (tmr_clr),
    .enable    (tmr_en),
    .expired   (tmr_exp)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wr_en   = 1'b0;
    wr_idx  = '0;
    ovf_d   = overflow;
    terr_d  = 1'b0;
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          wr_en   = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = FIRST_NEXT;
        end
      end
      COLLECT: begin
        tmr_clr = accept;
        tmr_en  = ~accept;
        if (accept) begin
          wr_en  = 1'b1;
          wr_idx = cnt;
          cnt_d  = cnt + CNT_W'(1);
          if (cnt == CNT_W'(BLOCK_BYTES - 1)) begin
            state_d = HOLD;
          end
        end else if (tmr_exp) begin
          state_d = IDLE;
          cnt_d   = '0;
          terr_d  = 1'b1;
        end
      end
      HOLD: begin
        unique case (1'b1)
          blk_ready & accept: begin
            wr_en   = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = FIRST_NEXT;
          end
          blk_ready & ~accept: begin
            cnt_d   = '0;
            state_d = IDLE;
          end
          ~blk_ready & accept: begin
            ovf_d = 1'b1;
          end
          ~blk_ready & ~accept: begin
          end
        endcase
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    data_d = blk_data;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (wr_idx == CNT_W'(i)) begin
        data_d[8*(BLOCK_BYTES-i)-1 -: 8] = rx_data;
      end
    end
  end

  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rx_valid_q  <= 1'b0;
      blk_data    <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      rx_valid_q  <= rx_valid;
      overflow    <= ovf_d;
      timeout_err <= terr_d;
      if (wr_en) begin
        blk_data <= data_d;
      end
    end
  end

endmodule

// File: tb/tb_uart_block_assembler.sv
// Directed bench for uart_block_assembler with a queue-based
// reference model checked every cycle plus literal block checks.
module tb_uart_block_assembler;

  localparam int  NB = 16;
  localparam int  TO = 500;

  logic           clk;
  logic           rst_n;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic [127:0]   blk_data;
  logic           blk_valid;
  logic           blk_ready;
  logic           busy;
  logic           overflow;
  logic           timeout_err;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;
  logic [127:0] last_blk = '0;

  uart_block_assembler dut (
    .uart_clock (clk),
    .uart_reset (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .blk_data   (blk_data),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .busy       (busy),
    .overflow   (overflow),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: bytes gathered in a queue, idle cycles counted.
  logic [7:0]   m_q[$];
  int           m_gap;
  bit           m_hold, m_ovf, m_terr, m_prev;
  logic [127:0] m_blk;

  always @(posedge clk) begin
    bit acc;
    if (!rst_n) begin
      m_q.delete();
      m_gap = 0; m_hold = 0; m_ovf = 0;
      m_terr = 0; m_prev = 0; m_blk = '0;
    end else begin
      acc = rx_valid && !m_prev;
      m_prev = rx_valid;
      m_terr = 0;
      if (m_hold) begin
        if (blk_ready) begin
          m_hold = 0;
          if (acc) begin
            m_q.delete();
            m_q.push_back(rx_data);
            m_gap = 0;
          end
        end else if (acc) begin
          m_ovf = 1;
        end
      end else if (acc) begin
        m_q.push_back(rx_data);
        m_gap = 0;
        if (m_q.size() == NB) begin
          for (int i = 0; i < NB; i++)
            m_blk[8*(NB-i)-1 -: 8] = m_q[i];
          m_hold = 1;
          m_q.delete();
        end
      end else if (m_q.size() > 0) begin
        m_gap++;
        if (m_gap == TO) begin
          m_terr = 1;
          m_q.delete();
          m_gap = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 128'(blk_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_ovf", 128'(overflow), 128'd0);
      chk("rst_terr", 128'(timeout_err), 128'd0);
      chk("rst_data", blk_data, 128'd0);
    end else begin
      chk("m_valid", 128'(blk_valid), 128'(m_hold));
      chk("m_busy", 128'(busy),
          128'(m_hold || m_q.size() > 0));
      chk("m_ovf", 128'(overflow), 128'(m_ovf));
      chk("m_terr", 128'(timeout_err), 128'(m_terr));
      if (m_hold) chk("m_data", blk_data, m_blk);
      if (blk_valid && blk_ready) begin
        hs_cnt++;
        last_blk = blk_data;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int hi, input int lo);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(hi);
    rx_valid = 1'b0;
    tick(lo);
  endtask

  task automatic send_run(input logic [7:0] first,
                          input int n);
    for (int i = 0; i < n; i++)
      send_byte(first + 8'(i), 1, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    rst_n = 1'b0; rx_data = '0;
    rx_valid = 1'b0; blk_ready = 1'b1;
    tick(3);
    chk("reset_data", blk_data, 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < NB; i++)
      send_byte(8'(i), 3, 2);
    tick(3);
    chk("full_hs", 128'(hs_cnt), 128'd1);
    chk("full_blk", last_blk,
        128'h000102030405060708090A0B0C0D0E0F);
    chk("full_ovf", 128'(overflow), 128'd0);

    send_byte(8'h80, 40, 2);
    send_run(8'h81, 15);
    tick(3);
    chk("level_hs", 128'(hs_cnt), 128'd2);
    chk("level_blk", last_blk,
        128'h808182838485868788898A8B8C8D8E8F);

    send_run(8'h10, 5);
    tick(498);
    chk("to_busy_pre", 128'(busy), 128'd1);
    chk("to_err_pre", 128'(timeout_err), 128'd0);
    tick(1);
    chk("to_err", 128'(timeout_err), 128'd1);
    chk("to_busy", 128'(busy), 128'd0);
    tick(1);
    chk("to_err_off", 128'(timeout_err), 128'd0);
    send_run(8'hA0, 16);
    tick(3);
    chk("to_blk", last_blk,
        128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);

    blk_ready = 1'b0;
    hs0 = hs_cnt;
    send_run(8'hC0, 16);
    tick(300);
    chk("bp_valid", 128'(blk_valid), 128'd1);
    send_byte(8'h77, 1, 1);
    chk("bp_ovf", 128'(overflow), 128'd1);
    chk("bp_blk", blk_data,
        128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
    blk_ready = 1'b1;
    tick(1);
    chk("bp_valid_off", 128'(blk_valid), 128'd0);
    chk("bp_ovf_stay", 128'(overflow), 128'd1);
    chk("bp_hs", 128'(hs_cnt - hs0), 128'd1);

    send_run(8'hE0, 8);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_data", blk_data, 128'd0);
    chk("ar_busy", 128'(busy), 128'd0);
    chk("ar_ovf", 128'(overflow), 128'd0);
    chk("ar_valid", 128'(blk_valid), 128'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send_run(8'h30, 16);
    tick(3);
    chk("ar_blk", last_blk,
        128'h303132333435363738393A3B3C3D3E3F);

    blk_ready = 1'b0;
    send_run(8'h40, 16);
    tick(2);
    rx_data = 8'h55; rx_valid = 1'b1; blk_ready = 1'b1;
    tick(1);
    rx_valid = 1'b0; blk_ready = 1'b0;
    chk("co_valid", 128'(blk_valid), 128'd0);
    chk("co_busy", 128'(busy), 128'd1);
    chk("co_ovf", 128'(overflow), 128'd0);
    chk("co_byte0", 128'(blk_data[127:120]), 128'h55);
    chk("co_prev", last_blk,
        128'h404142434445464748494A4B4C4D4E4F);
    tick(1);
    blk_ready = 1'b1;
    send_run(8'h56, 15);
    tick(3);
    chk("co_blk", last_blk,
        128'h55565758595A5B5C5D5E5F6061626364);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
